dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory access controller for the Harvard MIPS datapath.
- Sits between the MEM pipeline stage and the 32-bit word data RAM (2048 words, 11-bit word address).
- Accepts single-word or double-word load/store requests over a valid/ready handshake and sequences them onto the RAM's single address/data/write-enable port.
- Returns read data and write acknowledgements over a one-cycle response strobe.

Parameters:
- ADDR_W, 11, RAM word-address width.
- DATA_W, 32, RAM word width. Double-word accesses are 2*DATA_W bits wide.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_dbl  in  1  1 = double-word access (addr, addr+1).
- req_addr  in  ADDR_W  word address.
- req_wdata  in  2*DATA_W  store data. Low word goes to addr, high word goes to addr+1.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_err  out  1  qualifies rsp_valid: request rejected.
- rsp_rdata  out  2*DATA_W  load data; held until the next load response.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_dataIn  out  DATA_W  to RAM dataIn.
- ram_wen  out  1  to RAM wen.
- ram_data  in  DATA_W  from RAM data. Valid the cycle after ram_addr is presented.

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - ram_wen=0, ram_addr=0, ram_dataIn=0.
  - req_ready=1 from the first cycle after reset.
- Reset mid-operation:
  - Abandons the access at that edge; no response is issued.
  - ram_wen is 0 from that edge on.
  - A half-written double word stays half-written.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, RESP.
- Acceptance: in IDLE, req_valid at an edge latches we/dbl/addr/wdata (cycle T = accept cycle).
- Boundary error:
  - Condition: req_dbl=1 and req_addr=2^ADDR_W-1 (addr+1 would wrap).
  - Action: go to RESP with rsp_err=1; no RAM cycle is issued and ram_wen stays 0.
  - rsp_rdata is unchanged.
- Store path:
  - WR_LO: ram_addr=addr, ram_dataIn=wdata[31:0], ram_wen=1.
  - From WR_LO: next state WR_HI if dbl, else RESP.
  - WR_HI: ram_addr=addr+1, ram_dataIn=wdata[63:32], ram_wen=1. Next state RESP.
- Load path:
  - RD_LO: ram_addr=addr, ram_wen=0.
  - From RD_LO: if dbl go to RD_HI, else RD_CAP.
  - RD_HI: ram_addr=addr+1; capture ram_data into rsp_rdata[31:0] at the end of this cycle. Next state RD_CAP.
  - RD_CAP (single-word load): capture ram_data into rsp_rdata[31:0] and zero rsp_rdata[63:32].
  - RD_CAP (double-word load): capture ram_data into rsp_rdata[63:32].
  - RD_CAP next state: RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; next state IDLE.
  - req_ready=0 in RESP. No back-to-back acceptance; the minimum request spacing is latency+1.
- Latency (rsp_valid high in cycle):
  - Single store: T+2.
  - Double store: T+3.
  - Single load: T+3.
  - Double load: T+4.
  - Boundary error: T+1.
- RAM outputs:
  - ram_wen is 0 in every state except WR_LO and WR_HI.
  - ram_addr and ram_dataIn hold their last value outside active states.
- Ignored input changes: req_* changes while req_ready=0 are ignored; the latched copy is used.
- Address arithmetic: addr+1 is computed at ADDR_W bits. The wrap case never reaches the RAM because of the boundary error.

Test Plan:
- Reset, then single store addr=0x069 data=0x00000000_ABCD1234 -> ram_wen=1 with ram_addr=0x069 in T+1 only; rsp_valid pulse in T+2, rsp_err=0.
- Double store addr=0x047 data=0xFAFADEDE_BABA1111, then double load 0x047 -> RAM writes 0x047=BABA1111 and 0x048=FAFADEDE. Load rsp_rdata=0xFAFADEDE_BABA1111, with rsp_valid 4 cycles after accept.
- Single load 0x069 after the first scenario -> rsp_rdata=0x00000000_ABCD1234 at T+3; ram_wen=0 throughout.
- Double store at addr=0x7FF -> rsp_valid=1 and rsp_err=1 at T+1; ram_wen never asserts; a subsequent load of 0x7FF returns the prior contents.
- Assert rst during WR_HI of a double store to 0x066 -> no rsp_valid; ram_wen=0 from the reset edge; req_ready=1 after reset. A load of 0x066 returns the low word only written.
- Hold req_valid=1 continuously with changing req_addr -> only the addresses sampled in IDLE cycles are accessed; req_ready is low in all non-IDLE cycles.

Source files
------------

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory access controller for the Harvard MIPS MEM stage
// Sequences single/double-word loads and stores onto a one-port synchronous-read word RAM.
module dmem_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_dbl,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_dataIn,
  output logic                  ram_wen,
  input  logic [DATA_W-1:0]     ram_data
);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, RESP} state_t;

  state_t                state_q, state_d;
  logic                  dbl_q, dbl_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2*DATA_W-1:0]   wdata_q, wdata_d;
  logic [2*DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_din_q, ram_din_d;

  logic                  accept;
  logic                  boundary;
  logic [ADDR_W-1:0]     addr_hi;

  assign accept   = (state_q == IDLE) && req_valid;
  assign boundary = req_dbl && (&req_addr);
  assign addr_hi  = addr_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (boundary)    state_d = RESP;
          else if (req_we) state_d = WR_LO;
          else             state_d = RD_LO;
        end
      end
      WR_LO:   state_d = dbl_q ? WR_HI : RESP;
      WR_HI:   state_d = RESP;
      RD_LO:   state_d = dbl_q ? RD_HI : RD_CAP;
      RD_HI:   state_d = RD_CAP;
      RD_CAP:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ram_wen is masked by rst so the write under way when reset arrives is dropped.
  always_comb begin
    req_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == RESP);
    rsp_err    = (state_q == RESP) && err_q;
    ram_wen    = 1'b0;
    ram_addr   = ram_addr_q;
    ram_dataIn = ram_din_q;
    case (state_q)
      WR_LO: begin
        ram_addr   = addr_q;
        ram_dataIn = wdata_q[DATA_W-1:0];
        ram_wen    = !rst;
      end
      WR_HI: begin
        ram_addr   = addr_hi;
        ram_dataIn = wdata_q[2*DATA_W-1:DATA_W];
        ram_wen    = !rst;
      end
      RD_LO:   ram_addr = addr_q;
      RD_HI:   ram_addr = addr_hi;
      default: ;
    endcase
  end

  always_comb begin
    dbl_d      = dbl_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr;
    ram_din_d  = ram_dataIn;
    if (accept) begin
      dbl_d   = req_dbl;
      err_d   = boundary;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    if (state_q == RD_HI) rdata_d[DATA_W-1:0] = ram_data;
    if (state_q == RD_CAP) begin
      if (dbl_q) rdata_d[2*DATA_W-1:DATA_W] = ram_data;
      else       rdata_d = {{DATA_W{1'b0}}, ram_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbl_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      dbl_q      <= dbl_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a word-array reference model
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_dbl;
  logic [10:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_rdata;
  logic [10:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic        ram_wen;
  logic [31:0] ram_data;

  int          n_checks;
  int          n_errors;
  logic [31:0] ram_mem [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [63:0] last_rdata;
  bit          ram_clr;

  dmem_ctrl #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_dbl    (req_dbl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .ram_addr   (ram_addr),
    .ram_dataIn (ram_dataIn),
    .ram_wen    (ram_wen),
    .ram_data   (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 2048; i++) ram_mem[i] <= 32'h0;
    end else begin
      if (ram_wen) ram_mem[ram_addr] <= ram_dataIn;
      ram_data <= ram_mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble_req(input bit allow_valid);
    req_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_dbl   = 1'($urandom_range(0, 1));
    req_addr  = 11'($urandom);
    req_wdata = {$urandom, $urandom};
  endtask

  // Called at a falling edge inside an IDLE cycle; returns at the falling edge of the next IDLE cycle.
  task automatic do_req(input bit we, input bit dbl, input logic [10:0] addr, input logic [63:0] wdata);
    bit          err;
    int          exp_lat;
    int          exp_wen;
    int          lat;
    int          nwen;
    bit          ready_seen;
    logic [10:0] a1;
    logic [63:0] exp_rd;
    err     = dbl && (addr == 11'h7FF);
    exp_lat = err ? 1 : (we ? (dbl ? 3 : 2) : (dbl ? 4 : 3));
    exp_wen = (!err && we) ? (dbl ? 2 : 1) : 0;
    a1      = addr + 11'd1;
    if (!err && !we) exp_rd = dbl ? {ref_mem[a1], ref_mem[addr]} : {32'h0, ref_mem[addr]};
    else             exp_rd = last_rdata;

    req_valid = 1'b1;
    req_we    = we;
    req_dbl   = dbl;
    req_addr  = addr;
    req_wdata = wdata;
    check_eq("req_ready_idle", {63'h0, req_ready}, 64'h1);

    lat        = 0;
    nwen       = 0;
    ready_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (req_ready) ready_seen = 1;
      if (ram_wen) nwen++;
      scramble_req(1'b1);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("rsp_err", {63'h0, rsp_err}, {63'h0, err});
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("ready_busy", {63'h0, ready_seen}, 64'h0);
    check_eq("wen_cycles", 64'(nwen), 64'(exp_wen));

    if (!err && we) begin
      ref_mem[addr] = wdata[31:0];
      if (dbl) ref_mem[a1] = wdata[63:32];
    end
    last_rdata = exp_rd;

    @(negedge clk);
    check_eq("rsp_pulse", {63'h0, rsp_valid}, 64'h0);
    if (!err && we) begin
      check_eq("mem_lo", {32'h0, ram_mem[addr]}, {32'h0, ref_mem[addr]});
      if (dbl) check_eq("mem_hi", {32'h0, ram_mem[a1]}, {32'h0, ref_mem[a1]});
    end
  endtask

  initial begin
    int          bad;
    logic [10:0] ra;
    n_checks   = 0;
    n_errors   = 0;
    last_rdata = 64'h0;
    ram_clr    = 1'b1;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
    rst = 1'b1;
    scramble_req(1'b0);
    repeat (3) @(negedge clk);
    ram_clr = 1'b0;
    rst     = 1'b0;

    check_eq("rst_ready", {63'h0, req_ready}, 64'h1);
    check_eq("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check_eq("rst_rsp_err", {63'h0, rsp_err}, 64'h0);
    check_eq("rst_rdata", rsp_rdata, 64'h0);
    check_eq("rst_wen", {63'h0, ram_wen}, 64'h0);
    check_eq("rst_ram_addr", {53'h0, ram_addr}, 64'h0);
    check_eq("rst_ram_din", {32'h0, ram_dataIn}, 64'h0);

    do_req(1'b1, 1'b0, 11'h069, 64'h00000000_ABCD1234);
    do_req(1'b1, 1'b1, 11'h047, 64'hFAFADEDE_BABA1111);
    do_req(1'b0, 1'b1, 11'h047, 64'h0);
    check_eq("dbl_load_const", rsp_rdata, 64'hFAFADEDE_BABA1111);
    do_req(1'b0, 1'b0, 11'h069, 64'h0);
    check_eq("sgl_load_const", rsp_rdata, 64'h00000000_ABCD1234);
    do_req(1'b1, 1'b0, 11'h7FF, 64'h0BAD0BAD_13572468);
    do_req(1'b1, 1'b1, 11'h7FF, 64'hDEADBEEF_CAFEF00D);
    do_req(1'b0, 1'b0, 11'h7FF, 64'h0);
    check_eq("boundary_keep", rsp_rdata, 64'h00000000_13572468);

    // Reset lands while the high word of a double store is on the RAM port.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_dbl   = 1'b1;
    req_addr  = 11'h066;
    req_wdata = 64'h55556666_12345678;
    @(negedge clk);
    scramble_req(1'b0);
    @(negedge clk);
    check_eq("abort_wr_hi_wen", {63'h0, ram_wen}, 64'h1);
    rst = 1'b1;
    #1;
    check_eq("abort_wen_masked", {63'h0, ram_wen}, 64'h0);
    @(negedge clk);
    check_eq("abort_no_rsp", {63'h0, rsp_valid}, 64'h0);
    check_eq("abort_ready", {63'h0, req_ready}, 64'h1);
    check_eq("abort_wen", {63'h0, ram_wen}, 64'h0);
    rst = 1'b0;
    ref_mem[11'h066] = 32'h12345678;
    last_rdata = 64'h0;
    do_req(1'b0, 1'b1, 11'h066, 64'h0);
    check_eq("abort_half_word", rsp_rdata, {ref_mem[11'h067], 32'h12345678});

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 11'h7FF;
        1:       ra = 11'h7F0 + 11'($urandom_range(0, 15));
        default: ra = 11'($urandom_range(0, 31));
      endcase
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, {$urandom, $urandom});
    end

    bad = 0;
    for (int i = 0; i < 2048; i++) if (ram_mem[i] !== ref_mem[i]) bad++;
    check_eq("mem_final", 64'(bad), 64'h0);

    scramble_req(1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
